// File: rtl/i2c_mem_access_arbiter_pkg.sv
// Shared types and device constants for the I2C memory access arbiter.
package i2c_mem_access_arbiter_pkg;

  localparam int unsigned SLAVE_SIZE = 8;
  localparam logic [SLAVE_SIZE-2:0] SLAVE_ADDR = 7'h50;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/i2c_mem_access_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requesting index at or after ptr.
module i2c_mem_access_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [PTR_W-1:0]   gnt_idx_c,
  output logic               any_c
);

  int unsigned     idx;
  logic [PTR_W-1:0] sel;

  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    any_c     = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      sel = PTR_W'(idx);
      if (!any_c && req[sel]) begin
        any_c      = 1'b1;
        gnt_c[sel] = 1'b1;
        gnt_idx_c  = sel;
      end
    end
  end

endmodule

// File: rtl/i2c_mem_access_arbiter.sv
// Round-robin sharing of one I2C master between NUM_REQ requesters, one byte per grant.
// Optional NACK retry enabled by defining I2C_ARB_RETRY_EN.
module i2c_mem_access_arbiter
  import i2c_mem_access_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_rw,
  output logic [SLAVE_SIZE-2:0]     m_dev_addr,
  output logic [ADDR_W-1:0]         m_mem_addr,
  output logic [DATA_W-1:0]         m_wdata,
  input  logic                      m_done,
  input  logic                      m_nack,
  input  logic [DATA_W-1:0]         m_rdata
);

  localparam int unsigned PTR_W   = $clog2(NUM_REQ);
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYC);

  arb_state_t          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    gnt_idx_q, gnt_idx_d;
  logic [NUM_REQ-1:0]  gnt_oh_q, gnt_oh_d;
  mem_cmd_t            cmd_q, cmd_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                m_valid_d;
  logic [NUM_REQ-1:0]  rsp_done_d;
  logic [DATA_W-1:0]   rsp_rdata_d;
  logic                rsp_err_d;
  logic [NUM_REQ-1:0]  gnt_c;
  logic [PTR_W-1:0]    gnt_idx_c;
  logic                any_c;
`ifdef I2C_ARB_RETRY_EN
  localparam int unsigned RETRY_W = 3;
  logic [RETRY_W-1:0]  retry_q, retry_d;
`endif

  i2c_mem_access_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c),
    .any_c     (any_c)
  );

  assign m_rw       = cmd_q.rw;
  assign m_mem_addr = cmd_q.mem_addr;
  assign m_wdata    = cmd_q.wdata;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_oh_d    = gnt_oh_q;
    cmd_d       = cmd_q;
    timer_d     = timer_q;
    m_valid_d   = 1'b0;
    rsp_done_d  = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
`ifdef I2C_ARB_RETRY_EN
    retry_d     = retry_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_c) begin
          gnt_idx_d = gnt_idx_c;
          gnt_oh_d  = gnt_c;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) begin
              cmd_d.rw       = ~req_we[i];
              cmd_d.mem_addr = req_addr[ADDR_W*i +: ADDR_W];
              cmd_d.wdata    = req_wdata[DATA_W*i +: DATA_W];
            end
          end
`ifdef I2C_ARB_RETRY_EN
          retry_d = '0;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (m_valid && m_ready) begin
          timer_d = '0;
          state_d = WAIT;
        end else begin
          m_valid_d = 1'b1;
        end
      end
      WAIT: begin
        if (m_done) begin
`ifdef I2C_ARB_RETRY_EN
          if (m_nack && (retry_q < RETRY_W'(MAX_RETRY))) begin
            retry_d = retry_q + 1'b1;
            timer_d = '0;
            state_d = ISSUE;
          end else
`endif
          begin
            rsp_done_d  = gnt_oh_q;
            rsp_err_d   = m_nack;
            rsp_rdata_d = cmd_q.rw ? m_rdata : '0;
            state_d     = RESP;
          end
        end else if (timer_q == TIMER_W'(TIMEOUT_CYC - 1)) begin
          rsp_done_d = gnt_oh_q;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        ptr_d   = (gnt_idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      gnt_oh_q   <= '0;
      cmd_q      <= '0;
      timer_q    <= '0;
      m_valid    <= 1'b0;
      m_dev_addr <= '0;
      rsp_done   <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
`ifdef I2C_ARB_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_oh_q   <= gnt_oh_d;
      cmd_q      <= cmd_d;
      timer_q    <= timer_d;
      m_valid    <= m_valid_d;
      m_dev_addr <= SLAVE_ADDR;
      rsp_done   <= rsp_done_d;
      rsp_rdata  <= rsp_rdata_d;
      rsp_err    <= rsp_err_d;
`ifdef I2C_ARB_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

`ifndef SYNTHESIS
  a_params: assert property (@(posedge clk)
    (NUM_REQ >= 2) && (NUM_REQ <= 8) && (TIMEOUT_CYC >= 16) && (MAX_RETRY >= 1) && (MAX_RETRY <= 7));
  a_done_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(rsp_done));
  a_valid_hold: assert property (@(posedge clk) disable iff (!rst)
    (m_valid && !m_ready) |=> (m_valid && $stable({m_rw, m_mem_addr, m_wdata})));
  a_done_in_resp: assert property (@(posedge clk) disable iff (!rst) (|rsp_done) |-> (state_q == RESP));
`endif

endmodule

// File: tb/tb_i2c_mem_access_arbiter.sv
// Directed self-checking bench for i2c_mem_access_arbiter; the bench plays the I2C master by hand.
module tb_i2c_mem_access_arbiter;
  import i2c_mem_access_arbiter_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned TO = 64;
  localparam int unsigned MR = 3;
`ifdef I2C_ARB_RETRY_EN
  localparam int unsigned EXP_ALLNACK_CMDS = MR + 1;
  localparam int unsigned EXP_NA_CMDS      = 2;
  localparam int unsigned EXP_NA_ERR       = 0;
`else
  localparam int unsigned EXP_ALLNACK_CMDS = 1;
  localparam int unsigned EXP_NA_CMDS      = 1;
  localparam int unsigned EXP_NA_ERR       = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_we = '0;
  logic [NR*7-1:0]   req_addr = '0;
  logic [NR*8-1:0]   req_wdata = '0;
  logic [NR-1:0]     rsp_done;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic              m_rw;
  logic [6:0]        m_dev_addr;
  logic [6:0]        m_mem_addr;
  logic [7:0]        m_wdata;
  logic              m_done = 1'b0;
  logic              m_nack = 1'b0;
  logic [7:0]        m_rdata = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;
  int cmd_cnt  = 0;
  logic       cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;

  i2c_mem_access_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_valid(m_valid), .m_ready(m_ready), .m_rw(m_rw), .m_dev_addr(m_dev_addr),
    .m_mem_addr(m_mem_addr), .m_wdata(m_wdata),
    .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) for a command, record it, and let the accept edge pass.
  task automatic accept_cmd(output bit ok);
    int w = 0;
    ok = 1'b0;
    while (!(m_valid && m_ready) && w < 16) begin
      tick(1);
      w++;
    end
    if (!(m_valid && m_ready)) begin
      check_eq("cmd_wait_timeout", 32'(m_valid), 1);
      return;
    end
    ok = 1'b1;
    cmd_cnt++;
    cmd_rw    = m_rw;
    cmd_addr  = m_mem_addr;
    cmd_wdata = m_wdata;
    check_eq("dev_addr", 32'(m_dev_addr), 32'(SLAVE_ADDR));
    tick(1);
    check_eq("mvalid_drop", 32'(m_valid), 0);
  endtask

  task automatic serve(input logic nack, input logic [7:0] rd, input int dly);
    bit ok;
    accept_cmd(ok);
    if (!ok) return;
    tick(dly);
    m_done  = 1'b1;
    m_nack  = nack;
    m_rdata = rd;
    tick(1);
    m_done  = 1'b0;
    m_nack  = 1'b0;
    m_rdata = 8'hEE;
  endtask

  task automatic set_req(input int i, input logic we, input logic [6:0] a, input logic [7:0] d);
    req_we[i]          = we;
    req_addr[7*i +: 7] = a;
    req_wdata[8*i +: 8] = d;
    req_valid[i]       = 1'b1;
  endtask

  initial begin
    bit ok;
    #2 rst = 1'b0;
    tick(2);
    check_eq("rst_mvalid", 32'(m_valid), 0);
    check_eq("rst_rspdone", 32'(rsp_done), 0);
    check_eq("rst_devaddr", 32'(m_dev_addr), 0);
    check_eq("rst_rsperr", 32'(rsp_err), 0);
    rst = 1'b1;
    tick(1);

    // single write from req0 with a stalled master first
    m_ready = 1'b0;
    set_req(0, 1'b1, 7'h05, 8'hA5);
    tick(1);
    check_eq("t1_lat1", 32'(m_valid), 0);
    tick(1);
    check_eq("t1_lat2", 32'(m_valid), 1);
    check_eq("t1_rw", 32'(m_rw), 0);
    check_eq("t1_addr", 32'(m_mem_addr), 'h05);
    check_eq("t1_wdata", 32'(m_wdata), 'hA5);
    tick(1);
    check_eq("t1_stall", 32'(m_valid), 1);
    m_ready = 1'b1;
    serve(1'b0, 8'h77, 2);
    check_eq("t1_done", 32'(rsp_done), 'b0001);
    check_eq("t1_err", 32'(rsp_err), 0);
    check_eq("t1_rdata", 32'(rsp_rdata), 0);
    req_valid[0] = 1'b0;
    tick(1);
    check_eq("t1_pulse", 32'(rsp_done), 0);
    tick(1);

    // single read from req2
    set_req(2, 1'b0, 7'h05, 8'h00);
    serve(1'b0, 8'hA5, 3);
    check_eq("t2_rw", 32'(cmd_rw), 1);
    check_eq("t2_addr", 32'(cmd_addr), 'h05);
    check_eq("t2_done", 32'(rsp_done), 'b0100);
    check_eq("t2_rdata", 32'(rsp_rdata), 'hA5);
    check_eq("t2_err", 32'(rsp_err), 0);
    req_valid[2] = 1'b0;
    tick(2);

    // contention from reset: grants 0,1,2,3,0
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 7'(32'h10 + i), 8'h00);
    for (int k = 0; k < 5; k++) begin
      serve(1'b0, 8'(32'h30 + k), 1);
      check_eq("t3_addr", 32'(cmd_addr), 32'h10 + (k % 4));
      check_eq("t3_done", 32'(rsp_done), 32'(1) << (k % 4));
      check_eq("t3_rdata", 32'(rsp_rdata), 32'h30 + k);
    end
    req_valid = '0;
    tick(2);
    check_eq("t3_idle_mvalid", 32'(m_valid), 0);
    check_eq("t3_idle_done", 32'(rsp_done), 0);

    // NACK on every attempt, write to top address
    cmd_cnt = 0;
    set_req(3, 1'b1, 7'h7F, 8'h3C);
    for (int k = 0; k < 8 && rsp_done == '0; k++) serve(1'b1, 8'h00, 1);
    check_eq("t5_cmds", 32'(cmd_cnt), EXP_ALLNACK_CMDS);
    check_eq("t5_done", 32'(rsp_done), 'b1000);
    check_eq("t5_err", 32'(rsp_err), 1);
    check_eq("t5_addr", 32'(cmd_addr), 'h7F);
    check_eq("t5_wdata", 32'(cmd_wdata), 'h3C);
    req_valid[3] = 1'b0;
    tick(2);

    // NACK then ACK
    cmd_cnt = 0;
    set_req(3, 1'b1, 7'h40, 8'h5A);
    for (int k = 0; k < 8 && rsp_done == '0; k++) serve(k == 0, 8'h00, 1);
    check_eq("t5b_cmds", 32'(cmd_cnt), EXP_NA_CMDS);
    check_eq("t5b_done", 32'(rsp_done), 'b1000);
    check_eq("t5b_err", 32'(rsp_err), EXP_NA_ERR);
    req_valid[3] = 1'b0;
    tick(2);

    // stray m_done while idle, then timeout on req1
    m_done = 1'b1;
    m_rdata = 8'h55;
    tick(1);
    m_done = 1'b0;
    m_rdata = 8'hEE;
    check_eq("t4_stray_done", 32'(rsp_done), 0);
    check_eq("t4_stray_valid", 32'(m_valid), 0);
    set_req(1, 1'b0, 7'h00, 8'h00);
    accept_cmd(ok);
    for (int c = 1; c <= int'(TO); c++) begin
      tick(1);
      if (c == int'(TO) - 1) check_eq("t4_early", 32'(rsp_done), 0);
    end
    check_eq("t4_done", 32'(rsp_done), 'b0010);
    check_eq("t4_err", 32'(rsp_err), 1);
    check_eq("t4_rdata", 32'(rsp_rdata), 0);
    req_valid[1] = 1'b0;
    tick(2);

    // reset while waiting on req2; rr pointer must restart at 0
    set_req(2, 1'b0, 7'h22, 8'h00);
    accept_cmd(ok);
    tick(3);
    rst = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(m_valid), 0);
    check_eq("t6_rst_done", 32'(rsp_done), 0);
    tick(1);
    rst = 1'b1;
    set_req(1, 1'b0, 7'h11, 8'h00);
    tick(1);
    check_eq("t6_no_rsp", 32'(rsp_done), 0);
    serve(1'b0, 8'h99, 1);
    check_eq("t6_grant_addr", 32'(cmd_addr), 'h11);
    check_eq("t6_done", 32'(rsp_done), 'b0010);
    check_eq("t6_rdata", 32'(rsp_rdata), 'h99);
    req_valid[1] = 1'b0;
    serve(1'b0, 8'h42, 1);
    check_eq("t6_req2_addr", 32'(cmd_addr), 'h22);
    check_eq("t6_req2_done", 32'(rsp_done), 'b0100);
    req_valid = '0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
